// File: rtl/pim_sweep_ctrl.sv
// Sweeps one PIM crossbar column-by-column per accepted feature vector and streams tagged ADC results.
// Latency: first out_valid RD_LAT+1 cycles after the input handshake, then one result per cycle.
// Backpressure: out_ready=0 fills the result FIFO; issue stops once in-flight + buffered reaches FIFO_DEPTH.
// Optional build macro PIM_RELU_EN clamps negative (MSB=1) ADC results to zero at FIFO push.

module pim_sweep_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             not_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;

    // Storage, pointers and occupancy; memory is cleared so the head reads zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data = mem[rd_ptr];
    assign not_empty = (count != '0);
endmodule

module pim_sweep_ctrl #(
    parameter int INPUT_SIZE = 96,
    parameter int DEPTH      = 5,
    parameter int ADC_P      = 8,
    parameter int NUM_COL    = 32,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INPUT_SIZE-1:0] in_feature,
    output logic                  pim_en,
    output logic [DEPTH-1:0]      pim_addr,
    output logic [INPUT_SIZE-1:0] pim_feature,
    input  logic [ADC_P-1:0]      pim_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADC_P-1:0]      out_data,
    output logic [DEPTH-1:0]      out_addr,
    output logic                  out_last,
    output logic                  busy
);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [DEPTH-1:0] LAST_ADDR = DEPTH'(NUM_COL - 1);
    localparam int ENTRY_W = 1 + DEPTH + ADC_P;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                            state;
    logic [OCC_W-1:0]                  occ;
    logic [OCC_W-1:0]                  occ_next;
    logic                              credit_next;
    logic                              pop;
    logic                              push;
    logic [RD_LAT-1:0]                 pipe_vld;
    logic [RD_LAT-1:0]                 pipe_last;
    logic [RD_LAT-1:0][DEPTH-1:0]      pipe_addr;
    logic [ADC_P-1:0]                  push_result;
    logic [ENTRY_W-1:0]                head_entry;

    assign pop  = out_valid & out_ready;
    assign push = pipe_vld[RD_LAT-1];

    // occ counts every issued read not yet popped: reads in the array pipeline plus FIFO entries.
    always_comb begin
        occ_next = occ;
        if (pim_en && !pop)      occ_next = occ + OCC_W'(1);
        else if (!pim_en && pop) occ_next = occ - OCC_W'(1);
        credit_next = (occ_next < OCC_W'(FIFO_DEPTH));
    end

    // Outstanding-read counter; it is what keeps the FIFO from overflowing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) occ <= '0;
        else      occ <= occ_next;
    end

    // Sweep FSM; pim_en/pim_addr are registered, using next-cycle credit to decide the next issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            pim_en      <= 1'b0;
            pim_addr    <= '0;
            pim_feature <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pim_feature <= in_feature;
                        pim_en      <= 1'b1;
                        pim_addr    <= '0;
                        in_ready    <= 1'b0;
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    // pim_addr holds the last issued column, so every later issue is pim_addr+1.
                    if (pim_en && pim_addr == LAST_ADDR) begin
                        pim_en <= 1'b0;
                        state  <= DRAIN;
                    end else if (credit_next) begin
                        pim_en   <= 1'b1;
                        pim_addr <= pim_addr + DEPTH'(1);
                    end else begin
                        pim_en <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (occ == '0) begin
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-latency pipeline carrying the tags of each issued column alongside the array access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
            pipe_addr <= '0;
        end else begin
            pipe_vld[0]  <= pim_en;
            pipe_last[0] <= pim_en && (pim_addr == LAST_ADDR);
            pipe_addr[0] <= pim_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
                pipe_addr[i] <= pipe_addr[i-1];
            end
        end
    end

`ifdef PIM_RELU_EN
    assign push_result = pim_result[ADC_P-1] ? '0 : pim_result;
`else
    assign push_result = pim_result;
`endif

    pim_sweep_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({pipe_last[RD_LAT-1], pipe_addr[RD_LAT-1], push_result}),
        .pop       (pop),
        .head_data (head_entry),
        .not_empty (out_valid)
    );

    assign {out_last, out_addr, out_data} = head_entry;
endmodule

// File: tb/tb_pim_sweep_ctrl.sv
// Directed bench for pim_sweep_ctrl: three instances (32 cols/lat 1, 32 cols/lat 3, 1 col/lat 1).
// Each DUT is paired with a small array model; checks use immediate assertions.
module tb_pim_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [95:0] feat = '0;
    int          pat = 0;
    int          checks = 0;
    int          errors = 0;

    logic v_a = 0, rdy_a, pen_a, or_a = 1, ov_a, ol_a, busy_a;
    logic v_b = 0, rdy_b, pen_b, or_b = 1, ov_b, ol_b, busy_b;
    logic v_c = 0, rdy_c, pen_c, or_c = 1, ov_c, ol_c, busy_c;
    logic [4:0]  paddr_a, paddr_b, paddr_c, oa_a, oa_b, oa_c;
    logic [95:0] pfeat_a, pfeat_b, pfeat_c;
    logic [7:0]  pres_a, pres_b, pres_c, od_a, od_b, od_c;
    logic [7:0]  res_b [3];

`ifdef PIM_RELU_EN
    localparam logic [7:0] EXP_F0 = 8'h00;
`else
    localparam logic [7:0] EXP_F0 = 8'hF0;
`endif

    always #5 clk = ~clk;

    pim_sweep_ctrl dut_a (.clk(clk), .rst(rst), .in_valid(v_a), .in_ready(rdy_a), .in_feature(feat),
        .pim_en(pen_a), .pim_addr(paddr_a), .pim_feature(pfeat_a), .pim_result(pres_a),
        .out_valid(ov_a), .out_ready(or_a), .out_data(od_a), .out_addr(oa_a), .out_last(ol_a), .busy(busy_a));
    pim_sweep_ctrl #(.RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .in_valid(v_b), .in_ready(rdy_b), .in_feature(feat),
        .pim_en(pen_b), .pim_addr(paddr_b), .pim_feature(pfeat_b), .pim_result(pres_b),
        .out_valid(ov_b), .out_ready(or_b), .out_data(od_b), .out_addr(oa_b), .out_last(ol_b), .busy(busy_b));
    pim_sweep_ctrl #(.NUM_COL(1)) dut_c (.clk(clk), .rst(rst), .in_valid(v_c), .in_ready(rdy_c), .in_feature(feat),
        .pim_en(pen_c), .pim_addr(paddr_c), .pim_feature(pfeat_c), .pim_result(pres_c),
        .out_valid(ov_c), .out_ready(or_c), .out_data(od_c), .out_addr(oa_c), .out_last(ol_c), .busy(busy_c));

    // Array content: pattern 0 is addr*3; pattern 1 puts F0,05 in the first two columns.
    function automatic logic [7:0] arr_f(input int p, input logic [4:0] a);
        if (p == 1 && a == 5'd0) return 8'hF0;
        if (p == 1 && a == 5'd1) return 8'h05;
        return 8'(a * 3);
    endfunction

    function automatic logic [7:0] exp_f(input int p, input int idx);
        if (p == 1 && idx == 0) return EXP_F0;
        if (p == 1 && idx == 1) return 8'h05;
        return 8'(idx * 3);
    endfunction

    // Array models with read latency 1 (a, c) and 3 (b).
    always_ff @(posedge clk) pres_a <= arr_f(pat, paddr_a);
    always_ff @(posedge clk) begin
        res_b[0] <= arr_f(0, paddr_b);
        res_b[1] <= res_b[0];
        res_b[2] <= res_b[1];
    end
    assign pres_b = res_b[2];
    always_ff @(posedge clk) pres_c <= pfeat_c[7:0];

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One sweep on dut_a with out_ready held high; checks latency, order, tags and return to idle.
    task automatic sweep_a(input logic [95:0] f, input int p, input string nm);
        int idx, cyc, first_vld;
        @(negedge clk);
        pat = p; feat = f; v_a = 1'b1; or_a = 1'b1;
        @(negedge clk);                 // first negedge after the accepting edge
        v_a = 1'b0; cyc = 1;
        chk({nm, "_first_pim_en"}, pen_a, 1);
        chk({nm, "_first_pim_addr"}, paddr_a, 0);
        chk({nm, "_pim_feature"}, pfeat_a, f);
        chk({nm, "_busy"}, busy_a, 1);
        chk({nm, "_in_ready_low"}, rdy_a, 0);
        idx = 0; first_vld = -1;
        while (idx < 32 && cyc < 200) begin
            if (ov_a) begin
                if (first_vld < 0) first_vld = cyc;
                chk($sformatf("%s_data%0d", nm, idx), od_a, exp_f(p, idx));
                chk($sformatf("%s_addr%0d", nm, idx), oa_a, idx);
                chk($sformatf("%s_last%0d", nm, idx), ol_a, (idx == 31));
                idx++;
            end
            @(negedge clk); cyc++;
        end
        // handshake edge + 2 edges = third negedge counted from the accepting edge
        chk({nm, "_first_valid_cycle"}, first_vld, 3);
        chk({nm, "_result_count"}, idx, 32);
        while (!rdy_a && cyc < 300) begin @(negedge clk); cyc++; end
        chk({nm, "_in_ready_back"}, rdy_a, 1);
        chk({nm, "_busy_idle"}, busy_a, 0);
        chk({nm, "_out_valid_idle"}, ov_a, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, cyc, pulses, resume, occ, maxo, nres, npulse, k;
        logic [95:0] cur_feat;
        logic [7:0] qexp[$];

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_in_ready", rdy_a, 1);
        chk("rst_out_valid", ov_a, 0);
        chk("rst_pim_en", pen_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_pim_addr", paddr_a, 0);
        chk("rst_pim_feature", pfeat_a, 0);
        chk("rst_out_data", od_a, 0);
        chk("rst_out_addr", oa_a, 0);
        chk("rst_out_last", ol_a, 0);
        chk("rst_b_idle", {rdy_b, busy_b, ov_b, pen_b}, 4'b1000);
        chk("rst_b_feature", pfeat_b, 0);
        chk("rst_c_idle", {rdy_c, busy_c, ov_c, pen_c}, 4'b1000);
        rst = 1'b1;

        // Single full sweep, out_ready high
        sweep_a(96'hA5A5_0000_1111_2222_3333_4444, 0, "sweep1");

        // Backpressure from the start
        @(negedge clk);
        feat = 96'h1234; v_a = 1'b1; or_a = 1'b0;
        @(negedge clk);
        v_a = 1'b0; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (pen_a) pulses++;
            @(negedge clk);
        end
        chk("bp_pulses", pulses, 4);
        chk("bp_pim_en_stalled", pen_a, 0);
        chk("bp_pim_addr_held", paddr_a, 3);
        chk("bp_head_valid", ov_a, 1);
        chk("bp_head_addr", oa_a, 0);
        chk("bp_head_data", od_a, 0);
        or_a = 1'b1; idx = 0; cyc = 0; resume = -1;
        while (idx < 32 && cyc < 200) begin
            if (pen_a && resume < 0) resume = int'(paddr_a);
            if (ov_a) begin
                chk($sformatf("bp_data%0d", idx), od_a, exp_f(0, idx));
                chk($sformatf("bp_addr%0d", idx), oa_a, idx);
                idx++;
            end
            @(negedge clk); cyc++;
        end
        chk("bp_resume_addr", resume, 4);
        chk("bp_result_count", idx, 32);
        while (!rdy_a && cyc < 300) begin @(negedge clk); cyc++; end
        chk("bp_in_ready_back", rdy_a, 1);

        // RD_LAT=3, out_ready toggling every cycle
        @(negedge clk);
        feat = 96'h77; v_b = 1'b1; or_b = 1'b0;
        @(negedge clk);
        v_b = 1'b0; idx = 0; cyc = 0; occ = 0; maxo = 0;
        while (idx < 32 && cyc < 400) begin
            or_b = cyc[0];
            if (occ > maxo) maxo = occ;
            if (ov_b && or_b) begin
                chk($sformatf("tog_data%0d", idx), od_b, exp_f(0, idx));
                chk($sformatf("tog_addr%0d", idx), oa_b, idx);
                chk($sformatf("tog_last%0d", idx), ol_b, (idx == 31));
                idx++;
            end
            occ = occ + int'(pen_b) - int'(ov_b && or_b);
            @(negedge clk); cyc++;
        end
        or_b = 1'b1;
        chk("tog_result_count", idx, 32);
        chk("tog_outstanding_le_4", (maxo <= 4), 1);

        // Async reset mid-sweep at issue addr 10
        @(negedge clk);
        pat = 0; feat = 96'hDEAD; v_a = 1'b1; or_a = 1'b1;
        @(negedge clk);
        v_a = 1'b0; cyc = 0;
        while (!(pen_a && paddr_a == 5'd10) && cyc < 100) begin @(negedge clk); cyc++; end
        chk("mid_addr10", paddr_a, 10);
        chk("mid_out_valid", ov_a, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_out_valid", ov_a, 0);
        chk("mid_rst_pim_en", pen_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_in_ready", rdy_a, 1);
        chk("mid_rst_pim_addr", paddr_a, 0);
        chk("mid_rst_pim_feature", pfeat_a, 0);
        chk("mid_rst_out_tags", {od_a, oa_a, ol_a}, 0);
        @(negedge clk);
        rst = 1'b1;
        sweep_a(96'hBEEF_0000_0000_0000_0000_0001, 0, "post_rst");

        // NUM_COL=1, in_valid held high: back-to-back sweeps with fresh features
        @(negedge clk);
        v_c = 1'b1; or_c = 1'b1; k = 0; nres = 0; npulse = 0; cur_feat = '0;
        for (int i = 0; i < 40; i++) begin
            if (pen_c) begin
                npulse++;
                chk($sformatf("c_addr%0d", npulse), paddr_c, 0);
                chk($sformatf("c_feature%0d", npulse), pfeat_c, cur_feat);
            end
            if (ov_c) begin
                chk($sformatf("c_data%0d", nres), od_c, (qexp.size() > 0) ? qexp.pop_front() : 8'hXX);
                chk($sformatf("c_last%0d", nres), ol_c, 1);
                chk($sformatf("c_oaddr%0d", nres), oa_c, 0);
                nres++;
            end
            if (rdy_c) begin
                k++;
                cur_feat = {88'(k), 8'((k * 16 + 5) & 8'h7F)};
                feat = cur_feat;
                qexp.push_back(cur_feat[7:0]);
            end
            @(negedge clk);
        end
        v_c = 1'b0;
        chk("c_sweeps_ge3", (nres >= 3), 1);

        // Two's-complement clamp (or pass-through) on F0/05
        repeat (10) @(negedge clk);
        sweep_a(96'h55, 1, "relu");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
